// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_pkg
// Description : Shared constants and FSM state encoding for the fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

   localparam int INSTR_W = 32;
   localparam int ENTRY_W = 2 * INSTR_W;   // {pc_plus_four, instruction}
   localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no request outstanding
      ST_WAIT = 2'd1,   // live request outstanding
      ST_DROP = 2'd2    // outstanding request made stale by a redirect
   } fq_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_fifo
// Description : DEPTH-entry circular buffer holding {pc+4, instruction}
//               entries. Push on a full queue is dropped unless a pop frees
//               the slot in the same cycle; pop on empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W
)(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = pop && (r_count != '0);
   assign w_do_push = push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

   // Pointer and occupancy tracking; flush empties the queue in one cycle.
   always_ff @(posedge clock) begin
      if (!reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

   // Entry storage; contents need no reset since empty slots are never shown.
   always_ff @(posedge clock) begin
      if (reset && !flush && w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   assign head_data = r_mem[r_rd_ptr];
   assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch front end. Issues one outstanding memory
//               request at a time, buffers returned instructions with their
//               pc+4, and flushes/restarts on a taken-branch redirect.
//               Optional macro FETCH_QUEUE_BYPASS_EN forwards a returning
//               instruction straight to the outputs when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int                 DEPTH    = 4,
   parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
)(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         redirect,
   input  logic [INSTR_W-1:0]           redirect_pc,
   output logic                         imem_req,
   output logic [INSTR_W-1:0]           imem_addr,
   input  logic                         imem_ack,
   input  logic [INSTR_W-1:0]           imem_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INSTR_W-1:0]           out_instruction,
   output logic [INSTR_W-1:0]           out_pc_plus_four,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   fq_state_t          r_state;
   logic [INSTR_W-1:0] r_fetch_pc;
   logic [INSTR_W-1:0] r_req_addr;
   logic               r_req;

   logic [ENTRY_W-1:0] w_head;
   logic [CNT_W-1:0]   w_count;
   logic [CNT_W-1:0]   w_count_next;
   logic [INSTR_W-1:0] w_next_pc;
   logic               w_ack_live;
   logic               w_fifo_valid;
   logic               w_bypass;
   logic               w_push;
   logic               w_pop;
   logic               w_room_after;
   logic               w_free_now;

   assign w_next_pc    = r_fetch_pc + PC_STEP;
   assign w_fifo_valid = (w_count != '0);
   // A response that actually delivers an instruction this cycle.
   assign w_ack_live   = reset && (r_state == ST_WAIT) && imem_ack && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_bypass = w_ack_live && !w_fifo_valid;
`else
   assign w_bypass = 1'b0;
`endif

   // Bypassed-and-accepted instructions never occupy a slot.
   assign w_push       = w_ack_live && !(w_bypass && out_ready);
   assign w_pop        = reset && !redirect && w_fifo_valid && out_ready;
   assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
   assign w_room_after = (w_count_next < CNT_W'(DEPTH));
   assign w_free_now   = (w_count < CNT_W'(DEPTH));

   fetch_queue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (redirect),
      .push      (w_push),
      .push_data ({w_next_pc, imem_data}),
      .pop       (w_pop),
      .head_data (w_head),
      .count     (w_count)
   );

   // Request FSM: one request in flight, issued only with a slot reserved.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_req      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (redirect) begin
                  r_fetch_pc <= redirect_pc;
               end else if (w_free_now) begin
                  r_state    <= ST_WAIT;
                  r_req      <= 1'b1;
                  r_req_addr <= r_fetch_pc;
               end
            end
            ST_WAIT: begin
               if (redirect) begin
                  r_fetch_pc <= redirect_pc;
                  if (imem_ack) begin
                     r_state <= ST_IDLE;
                     r_req   <= 1'b0;
                  end else begin
                     r_state <= ST_DROP;
                  end
               end else if (imem_ack) begin
                  r_fetch_pc <= w_next_pc;
                  if (w_room_after) begin
                     r_req_addr <= w_next_pc;
                  end else begin
                     r_state <= ST_IDLE;
                     r_req   <= 1'b0;
                  end
               end
            end
            ST_DROP: begin
               if (redirect) r_fetch_pc <= redirect_pc;
               if (imem_ack) begin
                  r_state <= ST_IDLE;
                  r_req   <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_req_addr;
   assign count     = w_count;

   // Present the queue head (or the forwarded response when bypassing).
   always_comb begin
      out_valid        = w_fifo_valid;
      out_instruction  = w_fifo_valid ? w_head[INSTR_W-1:0]       : '0;
      out_pc_plus_four = w_fifo_valid ? w_head[ENTRY_W-1:INSTR_W] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (w_bypass) begin
         out_valid        = 1'b1;
         out_instruction  = imem_data;
         out_pc_plus_four = w_next_pc;
      end
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue: directed vector table,
//               hand-written corner sequences, and a randomized run checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset, redirect, imem_req, imem_ack, out_valid, out_ready;
   logic [31:0] redirect_pc, imem_addr, imem_data, out_instruction, out_pc_plus_four;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clock            (clock),
      .reset            (reset),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ack         (imem_ack),
      .imem_data        (imem_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_instruction  (out_instruction),
      .out_pc_plus_four (out_pc_plus_four),
      .count            (count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] memfun(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h8C01_0004;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_data = '0; out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
   endtask

   typedef struct {
      logic        ack, ready, redir;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pcp4;
      int          exp_count;
   } vec_t;

   vec_t tbl [17];

   // random-phase model state
   logic [63:0] q[$];
   logic [63:0] entry, head;
   logic [31:0] exp_fetch, pend_addr, rnd;
   logic        stale, pend, delivered, exp_valid;
   int          n_pops, nvalid;
   logic [31:0] exp_out;

   initial begin
      // ack, ready, redir | req, addr, valid, pc+4, count
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   0};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h4,   1'b1, 32'h4,   1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8,   1'b1, 32'h4,   2};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hC,   1'b1, 32'h4,   3};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   4};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   4};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   3};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10,  1'b1, 32'hC,   2};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h14,  1'b1, 32'h10,  2};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h18,  1'b1, 32'h14,  2};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h18,  1'b0, 32'h0,   0};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h18,  1'b0, 32'h0,   0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0,   0};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h104, 1};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 1'b1, 32'h104, 1};

      // ---------------- table-driven directed vectors ----------------
      do_reset();
      for (int i = 0; i < 17; i++) begin
         imem_ack = 1'b0; out_ready = 1'b0; redirect = 1'b0;
         #1;
         chk($sformatf("row%0d req", i), imem_req, tbl[i].exp_req);
         if (tbl[i].exp_req) chk($sformatf("row%0d addr", i), imem_addr, tbl[i].exp_addr);
         chk($sformatf("row%0d valid", i), out_valid, tbl[i].exp_valid);
         chk($sformatf("row%0d count", i), 32'(count), tbl[i].exp_count);
         if (tbl[i].exp_valid) begin
            chk($sformatf("row%0d pcp4", i), out_pc_plus_four, tbl[i].exp_pcp4);
            chk($sformatf("row%0d instr", i), out_instruction, memfun(tbl[i].exp_pcp4 - 32'd4));
         end
         imem_ack    = tbl[i].ack;
         imem_data   = memfun(imem_addr);
         out_ready   = tbl[i].ready;
         redirect    = tbl[i].redir;
         redirect_pc = 32'h100;
         tick();
      end

      // ---------------- sustained throughput ----------------
      do_reset();
      out_ready = 1'b1;
      exp_out = 32'd4;
      nvalid = 0;
      for (int k = 0; k < 20; k++) begin
         imem_ack  = imem_req;
         imem_data = memfun(imem_addr);
         #1;
         if (k == 0) chk("thru idle req", imem_req, 1'b0);
         else begin
            chk("thru req", imem_req, 1'b1);
            chk("thru addr", imem_addr, 32'(4 * (k - 1)));
         end
         if (k >= 3) chk("thru valid", out_valid, 1'b1);
         if (out_valid) begin
            chk("thru pcp4", out_pc_plus_four, exp_out);
            chk("thru instr", out_instruction, memfun(exp_out - 32'd4));
            exp_out = exp_out + 32'd4;
            nvalid++;
         end
         tick();
      end
      chk("thru delivered>=18", 32'(nvalid >= 18), 32'd1);

      // ---------------- reset in WAIT with two queued ----------------
      do_reset();
      tick();
      imem_ack = 1'b1; imem_data = memfun(imem_addr);
      tick();
      imem_data = memfun(imem_addr);
      tick();
      imem_ack = 1'b0;
      #1;
      chk("rstw count before", 32'(count), 32'd2);
      chk("rstw req before", imem_req, 1'b1);
      reset = 1'b0;
      tick();
      chk("rstw req", imem_req, 1'b0);
      chk("rstw valid", out_valid, 1'b0);
      chk("rstw count", 32'(count), 32'd0);
      chk("rstw instr", out_instruction, 32'd0);
      chk("rstw pcp4", out_pc_plus_four, 32'd0);
      reset = 1'b1; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      #1;
      chk("rstw first req", imem_req, 1'b1);
      chk("rstw first addr", imem_addr, RESET_PC);
      chk("rstw late ack ignored", 32'(count), 32'd0);

      // ---------------- bypass / ack-to-valid latency ----------------
      do_reset();
      tick();
      imem_ack = 1'b1; imem_data = 32'h8C01_0004;
      #1;
      chk("byp same-cycle valid", out_valid, BYP);
      if (out_valid) chk("byp same-cycle instr", out_instruction, 32'h8C01_0004);
      tick();
      imem_ack = 1'b0;
      #1;
      chk("byp next valid", out_valid, 1'b1);
      chk("byp next instr", out_instruction, 32'h8C01_0004);
      chk("byp next pcp4", out_pc_plus_four, 32'h4);

      // ---------------- randomized run vs reference model ----------------
      do_reset();
      q.delete();
      exp_fetch = RESET_PC; stale = 1'b0; pend = 1'b0; pend_addr = '0; n_pops = 0;
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom_range(0, 149) != 0);
         redirect = ($urandom_range(0, 24) == 0);
         rnd      = $urandom;
         redirect_pc = (c % 7 == 0) ? 32'hFFFF_FFF0 : (rnd & 32'hFFFF_FFFC);
         imem_ack  = imem_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
         imem_data = (imem_ack && imem_req) ? memfun(imem_addr) : $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (pend) begin
            chk("rnd req held", imem_req, 1'b1);
            chk("rnd addr held", imem_addr, pend_addr);
         end
         chk("rnd count", 32'(count), 32'(q.size()));
         delivered = reset && imem_req && imem_ack && !stale && !redirect;
         entry = {exp_fetch + 32'd4, memfun(exp_fetch)};
         if (delivered) chk("rnd fetch addr", imem_addr, exp_fetch);
         exp_valid = (q.size() != 0) || (BYP && delivered);
         chk("rnd valid", out_valid, exp_valid);
         if (exp_valid) begin
            head = (q.size() != 0) ? q[0] : entry;
            chk("rnd instr", out_instruction, head[31:0]);
            chk("rnd pcp4", out_pc_plus_four, head[63:32]);
         end
         if (!reset) begin
            q.delete();
            exp_fetch = RESET_PC; stale = 1'b0; pend = 1'b0;
         end else begin
            if (delivered) begin
               q.push_back(entry);
               exp_fetch = exp_fetch + 32'd4;
            end
            if (exp_valid && out_ready && !redirect) begin
               void'(q.pop_front());
               n_pops++;
            end
            if (redirect) begin
               q.delete();
               exp_fetch = redirect_pc;
            end
            if (imem_req && imem_ack) stale = 1'b0;
            else if (imem_req && redirect) stale = 1'b1;
            pend      = imem_req && !imem_ack;
            pend_addr = imem_addr;
         end
         tick();
      end
      chk("rnd liveness", 32'(n_pops > 300), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
